axis_upcounter_checker: RTL
===========================

# axis_upcounter_checker

AXI4-Stream sink that receives the packetised 32-bit up-counter stream, typically looped back through the DMA MM2S path, and checks it beat by beat. It verifies the data sequence, TKEEP and TLAST placement against a programmed packet size. It also counts good packets and errors and exposes sticky error flags for software via the control register block. It is the receive-side counterpart of the counter source and closes the loopback test.

## Interface
- No parameters; data width fixed at 32 bits, TKEEP 4 bits.
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  32  received data beat.
- s_axis_tkeep  in  4  byte enables; must be 4'hF on every beat.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  sink ready (registered).
- packet_size  in  32  expected beats per packet; 0 is treated as 1.
- chk_en  in  1  level; 1 = checking enabled.
- clear  in  1  synchronous pulse; clears counters and flags.
- pkt_count  out  32  packets passed, wraps at 2^32.
- err_count  out  16  error beats, saturates at 16'hFFFF.
- err_data  out  1  sticky: tdata mismatch seen.
- err_keep  out  1  sticky: tkeep != 4'hF seen.
- err_last  out  1  sticky: tlast missing or misplaced.
- locked  out  1  1 while the FSM is in CHECK.

## Operation
- Accept = s_axis_tvalid & s_axis_tready. Only accepted beats are evaluated.
- FSM states:
  - IDLE: reset state. chk_en=0 forces IDLE from any state. Beats are accepted and discarded.
  - HUNT: entered from IDLE when chk_en=1. Beats are discarded until an accepted beat with tlast=1, then the FSM moves to CHECK with exp=0.
  - CHECK: every accepted beat is evaluated.
- Packet size register ps_q: loaded from packet_size (0 maps to 1) on every accepted beat where exp==0. A size change therefore takes effect only at a packet boundary.
- Checks in CHECK, all evaluated on the same beat:
  - tdata == exp.
  - tkeep == 4'hF.
  - tlast == (exp == ps_q-1), using ps_q as loaded on this beat when exp==0.
- Beat passes all checks:
  - tlast=1: exp<=0 and pkt_count++.
  - tlast=0: exp<=exp+1.
- Any check fails:
  - err_count++ (saturating) and the failing sticky flags are set.
  - Multiple failures on one beat still count as one error.
  - FSM goes to HUNT to resynchronise. The failing beat is not counted as a packet.
  - If the failing beat itself has tlast=1, the FSM goes directly to CHECK with exp=0 instead of HUNT.
- clear:
  - Zeroes pkt_count, err_count and all flags, and sets exp=0.
  - FSM goes to HUNT if chk_en=1, else IDLE.
  - A beat accepted in the same cycle as clear is discarded. clear wins over any count or flag update.
- Counter arithmetic: exp is 32-bit. pkt_count wraps. err_count holds at 16'hFFFF.

## Timing
- Reset values:
  - s_axis_tready=0, locked=0, FSM=IDLE.
  - pkt_count=0, err_count=0, all error flags=0, exp=0, ps_q=1.
- s_axis_tready rises on the first aclk edge after aresetn deasserts (no throttle).
- All status outputs are registered. They reflect an accepted beat on the edge that accepts it, visible the following cycle.
- chk_en is sampled every cycle. Deasserting it mid-packet returns the FSM to IDLE on the next edge, and counters hold their values.
- Sink never stalls for internal reasons. Throughput is 1 beat/cycle without throttle.
- Reset asserted mid-packet returns everything to reset values immediately (asynchronous).

## Configuration
- CHK_THROTTLE_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reset to seed) advances every cycle.
  - s_axis_tready is registered as 0 when lfsr[1:0]==2'b00, else 1. This gives about 25% backpressure to exercise the upstream DMA and source stall handling.
  - Checking results are identical to the unthrottled case.
- CHK_THROTTLE_EN undefined: no LFSR; s_axis_tready=1 continuously after reset release.

## Test plan
- packet_size=4, chk_en=1, source sends 0,1,2,3(last) repeatedly after one lead-in tlast -> locked=1; pkt_count=10 after 10 packets; err_count=0; flags 0.
- packet_size=1, each beat data 0 with tlast=1 -> pkt_count increments every beat; err_count=0.
- packet_size=4, beat 2 carries data 5 -> err_data=1, err_count=1, locked drops; next tlast relocks; following good packets counted.
- packet_size=4, tlast on beat 2 (data 0,1,2 last) -> err_last=1, err_count=1, FSM goes straight to CHECK with exp=0. packet_size=4, tkeep=4'h7 on beat 0 -> err_keep=1.
- Force 70000 single-beat errors -> err_count=16'hFFFF. clear pulse coincident with a valid beat -> all counters and flags 0, beat ignored, FSM=HUNT.
- With CHK_THROTTLE_EN, 1000 packets of size 16 -> tready low in about 25% of cycles, pkt_count=1000, err_count=0. Assert aresetn low mid-packet -> all outputs return to reset values.

Source files
------------

// File: rtl/axis_upcounter_checker.sv
// AXI4-Stream sink that checks a packetised 32-bit up-counter stream.
// Optional CHK_THROTTLE_EN adds LFSR-driven backpressure on tready.
module axis_upcounter_checker (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] packet_size,
  input  logic        chk_en,
  input  logic        clear,
  output logic [31:0] pkt_count,
  output logic [15:0] err_count,
  output logic        err_data,
  output logic        err_keep,
  output logic        err_last,
  output logic        locked
);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CHECK
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] ps_q, ps_d;
  logic [31:0] pkt_q, pkt_d;
  logic [15:0] err_q, err_d;
  logic        ed_q, ed_d;
  logic        ek_q, ek_d;
  logic        el_q, el_d;
  logic        rdy_q, rdy_d;

  logic        acc;
  logic [31:0] ps_in;
  logic [31:0] ps_cur;
  logic        bad_data;
  logic        bad_keep;
  logic        bad_last;
  logic        bad;

`ifdef CHK_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d = {lfsr_q[14:0], fb};
  assign rdy_d  = (lfsr_q[1:0] != 2'b00);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
`else
  assign rdy_d = 1'b1;
`endif

  assign acc    = s_axis_tvalid & rdy_q;
  assign ps_in  = (packet_size == 32'd0) ? 32'd1 : packet_size;
  // The size is only sampled at a packet boundary (exp == 0).
  assign ps_cur = (exp_q == 32'd0) ? ps_in : ps_q;

  assign bad_data = (s_axis_tdata != exp_q);
  assign bad_keep = (s_axis_tkeep != 4'hF);
  assign bad_last = (s_axis_tlast != (exp_q == ps_cur - 32'd1));
  assign bad      = bad_data | bad_keep | bad_last;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    ps_d    = ps_q;
    pkt_d   = pkt_q;
    err_d   = err_q;
    ed_d    = ed_q;
    ek_d    = ek_q;
    el_d    = el_q;
    if (clear) begin
      pkt_d   = '0;
      err_d   = '0;
      ed_d    = 1'b0;
      ek_d    = 1'b0;
      el_d    = 1'b0;
      exp_d   = '0;
      state_d = chk_en ? HUNT : IDLE;
    end else begin
      if (acc && exp_q == 32'd0) ps_d = ps_in;
      if (!chk_en) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d = HUNT;
            exp_d   = '0;
          end
          HUNT: begin
            if (acc && s_axis_tlast) begin
              state_d = CHECK;
              exp_d   = '0;
            end
          end
          CHECK: begin
            if (acc) begin
              if (bad) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                ed_d    = ed_q | bad_data;
                ek_d    = ek_q | bad_keep;
                el_d    = el_q | bad_last;
                exp_d   = '0;
                // A failing tlast beat is itself a packet boundary.
                state_d = s_axis_tlast ? CHECK : HUNT;
              end else if (s_axis_tlast) begin
                exp_d = '0;
                pkt_d = pkt_q + 32'd1;
              end else begin
                exp_d = exp_q + 32'd1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      exp_q   <= '0;
      ps_q    <= 32'd1;
      pkt_q   <= '0;
      err_q   <= '0;
      ed_q    <= 1'b0;
      ek_q    <= 1'b0;
      el_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      ps_q    <= ps_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
      ed_q    <= ed_d;
      ek_q    <= ek_d;
      el_q    <= el_d;
      rdy_q   <= rdy_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign pkt_count     = pkt_q;
  assign err_count     = err_q;
  assign err_data      = ed_q;
  assign err_keep      = ek_q;
  assign err_last      = el_q;
  assign locked        = (state_q == CHECK);

endmodule
